// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator, the detector blocks and their benches.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;

    // x^7 + x^6 + 1: the new bit enters at bit 0 and is the generator's output bit
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/seq_prbs7.sv
// PRBS-7 (x^7+x^6+1) generator, seeded from seq_pkg on reset; prbs_bit is the bit
// produced by the step taken when en is high.
module seq_prbs7
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic prbs_bit
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;
    logic [6:0] lfsr_next;

    always_comb begin
        lfsr_next = prbs7_step(lfsr_q);
        lfsr_d    = en ? lfsr_next : lfsr_q;
    end

    assign prbs_bit = lfsr_next[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= PRBS7_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, repeated with idle gaps.
// Define SEQ_GEN_PRBS_EN to fill the gaps from a PRBS-7 generator instead of the idle level.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             idle_level,
    output logic             xout,
    output logic             xout_valid,
    output logic             sop,
    output logic             busy,
    output logic             done
);

    localparam int              IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_ctr_q, gap_ctr_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             idle_lvl_q, idle_lvl_d;
    logic             xout_q, xout_d;
    logic             xout_valid_q, xout_valid_d;
    logic             sop_q, sop_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fill_bit;

`ifdef SEQ_GEN_PRBS_EN
    logic prbs_en;
    logic prbs_bit;

    assign prbs_en  = (state_d == ST_GAP);
    assign fill_bit = prbs_bit;

    seq_prbs7 u_prbs7 (
        .clk      (clk),
        .reset    (reset),
        .en       (prbs_en),
        .prbs_bit (prbs_bit)
    );
`else
    assign fill_bit = idle_lvl_d;
`endif

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        remaining_d = remaining_q;
        gap_ctr_d   = gap_ctr_q;
        pat_d       = pat_q;
        gap_len_d   = gap_len_q;
        idle_lvl_d  = idle_lvl_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_d       = pattern;
                        gap_len_d   = gap;
                        idle_lvl_d  = idle_level;
                        bit_idx_d   = '0;
                        remaining_d = repeat_cnt;
                        state_d     = (repeat_cnt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_idx_q == LAST_IDX) begin
                        remaining_d = remaining_q - CNT_W'(1);
                        bit_idx_d   = '0;
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else if (gap_len_q != '0) begin
                            state_d   = ST_GAP;
                            gap_ctr_d = gap_len_q;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_ctr_q == GAP_W'(1)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        gap_ctr_d = gap_ctr_q - GAP_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state being entered so they line up with it once registered
    always_comb begin
        xout_d       = idle_lvl_d;
        xout_valid_d = 1'b0;
        sop_d        = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            ST_SHIFT: begin
                xout_d       = pat_d[LAST_IDX - bit_idx_d];
                xout_valid_d = 1'b1;
                sop_d        = (bit_idx_d == '0);
                busy_d       = 1'b1;
            end
            ST_GAP: begin
                xout_d = fill_bit;
                busy_d = 1'b1;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            remaining_q  <= '0;
            gap_ctr_q    <= '0;
            pat_q        <= '0;
            gap_len_q    <= '0;
            idle_lvl_q   <= 1'b0;
            xout_q       <= 1'b0;
            xout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            remaining_q  <= remaining_d;
            gap_ctr_q    <= gap_ctr_d;
            pat_q        <= pat_d;
            gap_len_q    <= gap_len_d;
            idle_lvl_q   <= idle_lvl_d;
            xout_q       <= xout_d;
            xout_valid_q <= xout_valid_d;
            sop_q        <= sop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign xout       = xout_q;
    assign xout_valid = xout_valid_q;
    assign sop        = sop_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
